pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage 8-bit MIPS pipeline. Watches ID operands,
//  the ID/EX load destination, the EX/MEM branch decision (pc_src) and the data-memory handshake.
//  Drives hold/bubble/flush enables to PC, IF/ID, ID/EX and EX/MEM, with saturating perf counters.
//  Sits beside the pipeline registers; it never touches datapath values.
// PARAMETERS
//  REG_W      3   register-address width (8 regs; reg 0 hard-wired zero)
//  CNT_W      16  width of stall/flush perf counters
//  MEM_TMO    15  max MEM_WAIT cycles before ERROR (>=1)
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      synchronous, active-high reset
//  id_rs           in   REG_W  source reg A of instr in ID
//  id_rt           in   REG_W  source reg B of instr in ID
//  id_uses_rt      in   1      ID instr reads rt as a source
//  idex_mem_read   in   1      instr in EX is a load
//  idex_dest       in   REG_W  destination reg of instr in EX
//  exmem_pc_src    in   2      pc_src from EX/MEM; 2'b00 = sequential, else redirect
//  mem_req         in   1      MEM stage is accessing data memory this cycle
//  mem_ready       in   1      data memory completes the access
//  hold_pc         out  1      PC keeps its value
//  hold_ifid       out  1      IF/ID keeps its contents
//  hold_idex       out  1      ID/EX keeps its contents
//  hold_exmem      out  1      EX/MEM keeps its contents
//  bubble_idex     out  1      ID/EX loads zero control (NOP)
//  flush_ifid      out  1      IF/ID loads NOP
//  flush_idex      out  1      ID/EX loads zero control
//  redirect        out  1      PC selects branch target this cycle
//  err             out  1      sticky memory-timeout flag
//  stall_cnt       out  CNT_W  cycles with hold_pc=1 (saturating)
//  flush_cnt       out  CNT_W  redirects taken (saturating)
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, err=0; rst=1 forces all control outputs 0.
//  Reset mid-MEM_WAIT or in ERROR returns to RUN the next cycle; no held state survives.
//  States (2-bit): RUN=0, MEM_WAIT=1, ERROR=2; code 3 -> RUN next cycle.
//  Control outputs are combinational from state+inputs (zero latency); state/counters registered.
//  Detection terms:
//   lu  = idex_mem_read & idex_dest!=0 & (idex_dest==id_rs | id_uses_rt & idex_dest==id_rt)
//   br  = exmem_pc_src != 2'b00
//   mw  = mem_req & ~mem_ready
//  RUN, priority mw > br > lu:
//   mw: hold_pc=hold_ifid=hold_idex=hold_exmem=1, no flush/redirect; next=MEM_WAIT, wait_cnt=1.
//   br: redirect=1, flush_ifid=1, flush_idex=1; lu ignored (its ID instr is flushed).
//   lu: hold_pc=1, hold_ifid=1, bubble_idex=1; single cycle (load advances, lu clears).
//   none: all outputs 0.
//  MEM_WAIT: all four holds=1 while ~mem_ready; wait_cnt++.
//   mem_ready=1: holds drop in that same cycle, outputs evaluated as in RUN with mw=0, next=RUN.
//   A branch frozen in EX/MEM redirects on the release cycle, never earlier.
//   wait_cnt==MEM_TMO & ~mem_ready -> next=ERROR.
//  ERROR: all four holds=1, err=1, no flush/redirect; leaves only on rst.
//  flush_cnt += 1 each cycle redirect=1; stall_cnt += 1 each cycle hold_pc=1.
//   Both saturate at all-ones, no wrap.
//  Outputs mutually consistent: never hold_* together with flush_*/redirect in the same cycle.
// STRUCTURE
//  Shared pkg (pipeline_pkg): state encodings, PC_SRC_SEQ=2'b00, REG_ZERO=0.
//  One sub-module: sat_counter (CNT_W, inc, rst) instanced for stall_cnt and flush_cnt.
//  Hazard compare logic stays inline.
// TESTING
//  1 lu: idex_mem_read=1, idex_dest=3, id_rs=3 -> 1 cycle hold_pc=hold_ifid=bubble_idex=1;
//    stall_cnt 0->1.
//  2 lu on r0: idex_dest=0, id_rs=0, idex_mem_read=1 -> no stall.
//    id_uses_rt=0, id_rt=3, idex_dest=3 -> no stall.
//  3 br+lu same cycle: exmem_pc_src=2'b01, lu true -> redirect=flush_ifid=flush_idex=1,
//    bubble_idex=0; flush_cnt=1.
//  4 mem wait 3 cycles, pc_src=2'b10 held: holds=1 for 3 cycles, no redirect;
//    release cycle redirect=1, state RUN.
//  5 timeout MEM_TMO=4, mem_ready stuck 0 -> ERROR after 4 wait cycles, err=1 sticky;
//    rst -> err=0, RUN.
//  6 saturation CNT_W=4: 20 consecutive lu stalls -> stall_cnt=15, no wrap.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_pkg;

    // Sequencer states; code 3 is unused and recovers to RUN.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2,
        ST_UNUSED   = 2'd3
    } state_t;

    // EX/MEM pc_src value meaning "no redirect".
    localparam logic [1:0] PC_SRC_SEQ = 2'b00;

    // Register 0 is hard-wired to zero, so it never carries a load hazard.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter for the hazard sequencer's perf counters.
// Latency: count updates one clk after i_inc; sticks at all-ones.
// Backpressure: none; i_inc is sampled every cycle.
//
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset (clears the count)
//   i_inc  add one this cycle
//   o_cnt  current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, branch, data-memory wait).
// Latency: control outputs are combinational from state+inputs; state/counters registered.
// Backpressure: a data-memory wait freezes PC..EX/MEM until mem_ready; timeout latches ERROR.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt         ID-stage source operands
//   idex_mem_read, idex_dest         load in EX and its destination
//   exmem_pc_src                     branch decision in EX/MEM (00 = sequential)
//   mem_req, mem_ready               data-memory handshake
//   hold_*, bubble_idex, flush_*     pipeline-register enables
//   redirect                         PC takes the branch target
//   err                              sticky memory-timeout flag
//   stall_cnt, flush_cnt             saturating perf counters
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_W   = 3,
    parameter int CNT_W   = 16,
    parameter int MEM_TMO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_dest,
    input  logic [1:0]       exmem_pc_src,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             hold_pc,
    output logic             hold_ifid,
    output logic             hold_idex,
    output logic             hold_exmem,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             redirect,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MEM_TMO + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WC_W-1:0] r_wait_cnt;
    logic [WC_W-1:0] w_wait_cnt_nxt;

    logic w_lu;
    logic w_br;
    logic w_mw;
    logic w_freeze;
    logic w_release;

    // Hazard detection terms.
    assign w_lu = idex_mem_read
                && (idex_dest != REG_W'(REG_ZERO))
                && ((idex_dest == id_rs) || (id_uses_rt && (idex_dest == id_rt)));
    assign w_br = (exmem_pc_src != PC_SRC_SEQ);
    assign w_mw = mem_req && !mem_ready;

    // Freeze: everything up to EX/MEM holds (memory stall or error lockup).
    // Release: normal branch/load-use evaluation; in MEM_WAIT this is the
    // cycle mem_ready arrives, so a branch frozen in EX/MEM redirects only now.
    assign w_freeze  = ((r_state == ST_RUN) && w_mw)
                    || ((r_state == ST_MEM_WAIT) && !mem_ready)
                    || (r_state == ST_ERROR);
    assign w_release = ((r_state == ST_RUN) && !w_mw)
                    || ((r_state == ST_MEM_WAIT) && mem_ready);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mw) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = WC_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WC_W'(MEM_TMO)) begin
                    w_state_nxt    = ST_ERROR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
                end
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // Output logic; reset forces every control output low.
    always_comb begin
        hold_pc     = 1'b0;
        hold_ifid   = 1'b0;
        hold_idex   = 1'b0;
        hold_exmem  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        redirect    = 1'b0;
        err         = 1'b0;
        if (!rst) begin
            if (w_freeze) begin
                hold_pc    = 1'b1;
                hold_ifid  = 1'b1;
                hold_idex  = 1'b1;
                hold_exmem = 1'b1;
                err        = (r_state == ST_ERROR);
            end else if (w_release) begin
                if (w_br) begin
                    // The ID instruction is flushed, so a load-use on it is moot.
                    redirect   = 1'b1;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (w_lu) begin
                    hold_pc     = 1'b1;
                    hold_ifid   = 1'b1;
                    bubble_idex = 1'b1;
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (hold_pc),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (redirect),
        .o_cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=4, MEM_TMO=4).
// Inputs driven 1 time unit after posedge; outputs sampled before the next edge.
// Every expectation is a hand-computed constant.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs, id_rt, idex_dest;
    logic       id_uses_rt, idex_mem_read;
    logic [1:0] exmem_pc_src;
    logic       mem_req, mem_ready;
    logic       hold_pc, hold_ifid, hold_idex, hold_exmem;
    logic       bubble_idex, flush_ifid, flush_idex, redirect, err;
    logic [3:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // {hold_pc, hold_ifid, hold_idex, hold_exmem, bubble_idex, flush_ifid, flush_idex, redirect, err}
    localparam logic [8:0] C_NONE = 9'b0000_0000_0;
    localparam logic [8:0] C_LU   = 9'b1100_1000_0;
    localparam logic [8:0] C_BR   = 9'b0000_0111_0;
    localparam logic [8:0] C_HOLD = 9'b1111_0000_0;
    localparam logic [8:0] C_ERR  = 9'b1111_0000_1;

    logic [8:0] ctrl;
    assign ctrl = {hold_pc, hold_ifid, hold_idex, hold_exmem, bubble_idex,
                   flush_ifid, flush_idex, redirect, err};

    pipeline_hazard_ctrl #(.REG_W(3), .CNT_W(4), .MEM_TMO(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .idex_mem_read (idex_mem_read),
        .idex_dest     (idex_dest),
        .exmem_pc_src  (exmem_pc_src),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .hold_pc       (hold_pc),
        .hold_ifid     (hold_ifid),
        .hold_idex     (hold_idex),
        .hold_exmem    (hold_exmem),
        .bubble_idex   (bubble_idex),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .redirect      (redirect),
        .err           (err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs         = 3'd0;
        id_rt         = 3'd0;
        id_uses_rt    = 1'b0;
        idex_mem_read = 1'b0;
        idex_dest     = 3'd0;
        exmem_pc_src  = 2'b00;
        mem_req       = 1'b0;
        mem_ready     = 1'b0;
    endtask

    task automatic set_lu();
        idex_mem_read = 1'b1;
        idex_dest     = 3'd3;
        id_rs         = 3'd3;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        set_lu();
        #2;
        check("rst_ctrl_zero", 32'(ctrl), 32'(C_NONE));
        tick();
        tick();
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'd0);
        rst = 1'b0;
        idle_inputs();
        #1;
        check("run_idle", 32'(ctrl), 32'(C_NONE));

        // Load-use on rs: one stall cycle, then the load moves on.
        set_lu();
        #1;
        check("lu_ctrl", 32'(ctrl), 32'(C_LU));
        tick();
        idex_mem_read = 1'b0;
        #1;
        check("lu_cleared", 32'(ctrl), 32'(C_NONE));
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // r0 destination never stalls; rt only counts when used.
        idex_mem_read = 1'b1;
        idex_dest     = 3'd0;
        id_rs         = 3'd0;
        #1;
        check("lu_r0", 32'(ctrl), 32'(C_NONE));
        idex_dest  = 3'd3;
        id_rs      = 3'd1;
        id_rt      = 3'd3;
        id_uses_rt = 1'b0;
        #1;
        check("lu_rt_unused", 32'(ctrl), 32'(C_NONE));
        id_uses_rt = 1'b1;
        #1;
        check("lu_rt_used", 32'(ctrl), 32'(C_LU));
        tick();
        check("lu_rt_stall_cnt", 32'(stall_cnt), 32'd2);
        idle_inputs();

        // Branch beats load-use in the same cycle.
        exmem_pc_src = 2'b01;
        set_lu();
        #1;
        check("br_over_lu", 32'(ctrl), 32'(C_BR));
        tick();
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd2);
        idle_inputs();

        // Memory wait with a branch frozen in EX/MEM: 3 hold cycles, redirect on release.
        exmem_pc_src = 2'b10;
        mem_req      = 1'b1;
        mem_ready    = 1'b0;
        #1;
        check("mw_run_hold", 32'(ctrl), 32'(C_HOLD));
        tick();
        check("mw_state_wait", 32'(dut.r_state), 32'd1);
        for (int i = 0; i < 2; i++) begin
            check("mw_wait_hold", 32'(ctrl), 32'(C_HOLD));
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("mw_release_br", 32'(ctrl), 32'(C_BR));
        tick();
        check("mw_back_run", 32'(dut.r_state), 32'd0);
        check("mw_flush_cnt", 32'(flush_cnt), 32'd2);
        check("mw_stall_cnt", 32'(stall_cnt), 32'd5);
        idle_inputs();
        #1;
        check("mw_after_idle", 32'(ctrl), 32'(C_NONE));

        // Timeout: 1 RUN cycle + 4 MEM_WAIT cycles, then ERROR.
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("tmo_run_hold", 32'(ctrl), 32'(C_HOLD));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tmo_state_wait", 32'(dut.r_state), 32'd1);
            check("tmo_wait_hold", 32'(ctrl), 32'(C_HOLD));
        end
        tick();
        check("tmo_state_err", 32'(dut.r_state), 32'd2);
        check("tmo_err_ctrl", 32'(ctrl), 32'(C_ERR));
        check("tmo_stall_cnt", 32'(stall_cnt), 32'd10);
        mem_req   = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("err_sticky", 32'(ctrl), 32'(C_ERR));
        tick();
        check("err_sticky2", 32'(ctrl), 32'(C_ERR));
        check("err_stall_cnt", 32'(stall_cnt), 32'd11);
        rst = 1'b1;
        #1;
        check("err_rst_ctrl", 32'(ctrl), 32'(C_NONE));
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("err_rst_state", 32'(dut.r_state), 32'd0);
        check("err_rst_clear", 32'(ctrl), 32'(C_NONE));
        check("err_rst_stall", 32'(stall_cnt), 32'd0);
        check("err_rst_flush", 32'(flush_cnt), 32'd0);

        // 20 consecutive load-use stalls saturate a 4-bit counter at 15.
        set_lu();
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("sat_stall", 32'(stall_cnt), (i > 15) ? 32'd15 : 32'(i));
        end
        idle_inputs();

        // 20 consecutive redirects saturate flush_cnt; stall_cnt stays pinned.
        exmem_pc_src = 2'b11;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("sat_flush", 32'(flush_cnt), (i > 15) ? 32'd15 : 32'(i));
        end
        check("sat_stall_hold", 32'(stall_cnt), 32'd15);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
